// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory completer.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  // Wide enough for WAIT_STATES up to 15.
  localparam int CNT_W = 4;

  function automatic int byte_off_w(input int datawidth);
    return $clog2(datawidth / 8);
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB4 requester/completer signal bundle for one PSELx slot.
// A transfer completes on the rising edge where PSEL & PENABLE & PREADY are all
// high; PSLVERR and PRDATA are only meaningful on that cycle.
interface apb_mem_slave_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8
) ();

  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [ADDRWIDTH-1:0]   PADDR;
  logic [DATAWIDTH-1:0]   PWDATA;
  logic [DATAWIDTH/8-1:0] PSTRB;
  logic [DATAWIDTH-1:0]   PRDATA;
  logic                   PREADY;
  logic                   PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_bytewr_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered read port.
module apb_bytewr_ram #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 64,
  parameter int AW        = 6
) (
  input  logic                   clk,
  input  logic [DATAWIDTH/8-1:0] we,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DATAWIDTH-1:0]   wdata,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [DATAWIDTH-1:0]   rdata
);

  localparam int NB = DATAWIDTH / 8;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[wr_addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (rd_en) rdata <= mem[rd_addr];
  end

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 completer: word memory with byte strobes, fixed wait states and
// PSLVERR on out-of-range word indices.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  apb_mem_slave_if.slave  bus,
  output apb_state_t      dbg_state
);

  localparam int NB     = DATAWIDTH / 8;
  localparam int OFF_W  = byte_off_w(DATAWIDTH);
  localparam int IDX_W  = ADDRWIDTH - OFF_W;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RAM_AW-1:0]    addr_q;
  logic                 write_q;
  logic [DATAWIDTH-1:0] wdata_q;
  logic [NB-1:0]        strb_q;
  logic                 err_q;
  logic                 rd_valid_q, rd_valid_d;
  logic                 latch_en;
  logic                 ram_rd_en;
  logic [NB-1:0]        ram_we;
  logic [DATAWIDTH-1:0] ram_rdata;
  logic [IDX_W-1:0]     idx_in;
  logic                 in_range;
  logic                 ready;

  assign idx_in   = bus.PADDR[ADDRWIDTH-1:OFF_W];
  assign in_range = ({1'b0, idx_in} < (IDX_W+1)'(DEPTH));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    latch_en   = 1'b0;
    ram_rd_en  = 1'b0;
    ram_we     = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          state_d    = ACCESS;
          latch_en   = 1'b1;
          cnt_d      = CNT_W'(WAIT_STATES);
          rd_valid_d = !bus.PWRITE && in_range;
          ram_rd_en  = !bus.PWRITE && in_range;
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          // Requester abandoned the transfer: nothing commits.
          state_d    = IDLE;
          rd_valid_d = 1'b0;
        end else if (bus.PENABLE) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d    = IDLE;
            rd_valid_d = 1'b0;
            if (write_q && !err_q) ram_we = strb_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      if (latch_en) begin
        err_q   <= !in_range;
        write_q <= bus.PWRITE;
        addr_q  <= idx_in[RAM_AW-1:0];
        wdata_q <= bus.PWDATA;
        strb_q  <= bus.PSTRB;
      end
    end
  end

  apb_bytewr_ram #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (DEPTH),
    .AW        (RAM_AW)
  ) u_ram (
    .clk     (PCLK),
    .we      (ram_we),
    .wr_addr (addr_q),
    .wdata   (wdata_q),
    .rd_en   (ram_rd_en),
    .rd_addr (idx_in[RAM_AW-1:0]),
    .rdata   (ram_rdata)
  );

  // Responses come from flops only, never straight from the bus inputs.
  assign ready       = (state_q == ACCESS) && (cnt_q == '0);
  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready && err_q;
  assign bus.PRDATA  = rd_valid_q ? ram_rdata : '0;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: two instances (2 and 0 wait states, 16 words)
// checked every cycle against a transfer-level model, plus literal read-back checks.
module tb_apb_mem_slave;
  import apb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [2];

  // ---------------- bus drive / observe ----------------
  logic        psel [2], penable [2], pwrite [2];
  logic [7:0]  paddr [2];
  logic [31:0] pwdata [2];
  logic [3:0]  pstrb [2];
  logic        pready [2], pslverr [2];
  logic [31:0] prdata [2];
  apb_state_t  dbg [2];

  apb_mem_slave_if #(.DATAWIDTH(32), .ADDRWIDTH(8)) bus_a ();
  apb_mem_slave_if #(.DATAWIDTH(32), .ADDRWIDTH(8)) bus_b ();

  assign bus_a.PSEL = psel[0];    assign bus_b.PSEL = psel[1];
  assign bus_a.PENABLE = penable[0]; assign bus_b.PENABLE = penable[1];
  assign bus_a.PWRITE = pwrite[0];  assign bus_b.PWRITE = pwrite[1];
  assign bus_a.PADDR = paddr[0];    assign bus_b.PADDR = paddr[1];
  assign bus_a.PWDATA = pwdata[0];  assign bus_b.PWDATA = pwdata[1];
  assign bus_a.PSTRB = pstrb[0];    assign bus_b.PSTRB = pstrb[1];
  assign pready[0] = bus_a.PREADY;  assign pready[1] = bus_b.PREADY;
  assign pslverr[0] = bus_a.PSLVERR; assign pslverr[1] = bus_b.PSLVERR;
  assign prdata[0] = bus_a.PRDATA;  assign prdata[1] = bus_b.PRDATA;

  apb_mem_slave #(.DATAWIDTH(32), .ADDRWIDTH(8), .DEPTH(16), .WAIT_STATES(2)) dut_ws2 (
    .PCLK(clk), .PRESETn(rst_n[0]), .bus(bus_a), .dbg_state(dbg[0])
  );
  apb_mem_slave #(.DATAWIDTH(32), .ADDRWIDTH(8), .DEPTH(16), .WAIT_STATES(0)) dut_ws0 (
    .PCLK(clk), .PRESETn(rst_n[1]), .bus(bus_b), .dbg_state(dbg[1])
  );

  // ---------------- model state ----------------
  int          ws [2] = '{2, 0};
  logic [31:0] mdl [2][16];
  logic        exp_ready [2], exp_err [2];
  logic [31:0] exp_rdata [2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: every cycle, both instances ----------------
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d pready", u),  32'(pready[u]),  32'(exp_ready[u]));
      check($sformatf("u%0d pslverr", u), 32'(pslverr[u]), 32'(exp_err[u]));
      check($sformatf("u%0d prdata", u),  prdata[u],       exp_rdata[u]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_exp(input int u);
    psel[u] = 1'b0; penable[u] = 1'b0;
    exp_ready[u] = 1'b0; exp_err[u] = 1'b0; exp_rdata[u] = 32'h0;
  endtask

  // Called at the start of a cycle (#1 after a rising edge); returns at the
  // start of the cycle following completion, with the bus left idle.
  task automatic xfer(input int u, input bit wr, input logic [7:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err, output int waits);
    int idx;
    bit oor;
    idx = int'(addr) >> 2;
    oor = (idx >= 16);
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr;
    paddr[u] = addr; pwdata[u] = data; pstrb[u] = strb;
    exp_ready[u] = 1'b0; exp_err[u] = 1'b0; exp_rdata[u] = 32'h0;
    @(posedge clk); #1;
    penable[u] = 1'b1;
    waits = 0;
    rd = 32'h0; err = 1'b0;
    for (int k = 0; k <= ws[u]; k++) begin
      exp_ready[u] = (k == ws[u]);
      exp_err[u]   = (k == ws[u]) && oor;
      exp_rdata[u] = (!wr && !oor) ? mdl[u][idx] : 32'h0;
      if (!pready[u]) waits++;
      if (k == ws[u]) begin
        rd  = prdata[u];
        err = pslverr[u];
      end
      @(posedge clk); #1;
    end
    if (wr && !oor)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[u][idx][b*8 +: 8] = data[b*8 +: 8];
    idle_exp(u);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        err;
  int          w;

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0;
      pwrite[u] = 1'b0; paddr[u] = 8'h0; pwdata[u] = 32'h0; pstrb[u] = 4'h0;
      idle_exp(u);
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset state u0", 32'(dbg[0]), 32'(IDLE));
    check("reset state u1", 32'(dbg[1]), 32'(IDLE));
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Full write and read-back, two wait states.
    xfer(0, 1'b1, 8'h08, 32'hDEADBEEF, 4'hF, rd, err, w);
    check("wr08 waits", 32'(w), 32'd2);
    check("wr08 err", 32'(err), 32'd0);
    xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, err, w);
    check("rd08 data", rd, 32'hDEADBEEF);
    check("rd08 waits", 32'(w), 32'd2);

    // Partial strobe write.
    xfer(0, 1'b1, 8'h08, 32'h11223344, 4'b0101, rd, err, w);
    xfer(0, 1'b0, 8'h08, 32'h0, 4'hF, rd, err, w);
    check("rd08 strobed", rd, 32'hDE22BE44);

    // Out-of-range write must not alias onto word 0.
    xfer(0, 1'b1, 8'h00, 32'hCAFEF00D, 4'hF, rd, err, w);
    xfer(0, 1'b1, 8'h40, 32'h12345678, 4'hF, rd, err, w);
    check("wr40 err", 32'(err), 32'd1);
    xfer(0, 1'b0, 8'h40, 32'h0, 4'h0, rd, err, w);
    check("rd40 data", rd, 32'h0);
    check("rd40 err", 32'(err), 32'd1);
    xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, rd, err, w);
    check("rd00 after oor", rd, 32'hCAFEF00D);

    // Last word, unaligned addresses ignore the byte offset.
    xfer(0, 1'b1, 8'h3C, 32'h01020304, 4'hF, rd, err, w);
    xfer(0, 1'b1, 8'h3D, 32'hFF000000, 4'b1000, rd, err, w);
    xfer(0, 1'b0, 8'h3F, 32'h0, 4'h0, rd, err, w);
    check("rd3f data", rd, 32'hFF020304);
    check("rd3f err", 32'(err), 32'd0);

    // Abort: PSEL drops during a wait cycle, the write must not land.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 8'h08; pwdata[0] = 32'h0; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(posedge clk); #1;
    idle_exp(0);
    @(posedge clk); #1;
    check("abort state", 32'(dbg[0]), 32'(IDLE));
    xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, err, w);
    check("rd08 after abort", rd, 32'hDE22BE44);

    // Reset in the first wait cycle of a write.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 8'h08; pwdata[0] = 32'h0; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    rst_n[0] = 1'b0;
    #1;
    check("u0 reset state", 32'(dbg[0]), 32'(IDLE));
    idle_exp(0);
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, err, w);
    check("rd08 after reset", rd, 32'hDE22BE44);

    // Zero wait states, back-to-back write then read.
    xfer(1, 1'b1, 8'h0C, 32'hA5A5A5A5, 4'hF, rd, err, w);
    check("ws0 wr waits", 32'(w), 32'd0);
    xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, rd, err, w);
    check("ws0 rd waits", 32'(w), 32'd0);
    check("ws0 rd0c data", rd, 32'hA5A5A5A5);

    // Reset during the completing access cycle: PREADY drops at once.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 8'h0C; pwdata[1] = 32'h0; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    check("ws0 pre-reset pready", 32'(pready[1]), 32'd1);
    rst_n[1] = 1'b0;
    #1;
    check("ws0 reset pready", 32'(pready[1]), 32'd0);
    check("ws0 reset state", 32'(dbg[1]), 32'(IDLE));
    idle_exp(1);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, rd, err, w);
    check("ws0 rd0c after reset", rd, 32'hA5A5A5A5);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
